pipeline_run_ctrl: RTL and testbench
====================================

Name: pipeline_run_ctrl

Overview:
Execution controller for the 5-stage MIPS pipeline. It gates the pipeline's global enable so the pipeline can run freely, single-step, or clear, under commands from the debug host. It detects the HALT instruction in IF, drains in-flight instructions, then freezes the pipeline. It also keeps a cycle counter for the debug unit to read.

Parameters:
CNT_W, 32, width of cycle_count
HALT_OPCODE, 6'b111111, opcode field [31:26] that marks HALT
DRAIN_CYCLES, 4, enabled cycles after HALT fetch needed to retire ID/EX/MEM/WB contents

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  host command strobe
cmd  in  2  00 PAUSE, 01 RUN, 10 STEP, 11 CLEAR
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
instruction_IF  in  32  instruction currently in IF stage
stallF  in  1  hazard-unit fetch stall
pipe_en  out  1  global enable to PC, stage registers, register-file write
if_flush  out  1  forces NOP into IF-ID register
pipe_clear  out  1  one-cycle clear of PC and stage registers
halted  out  1  high while in HALTED
done  out  1  one-cycle pulse on entry to HALTED
busy  out  1  high in RUN, STEP, DRAIN, CLEAR
cycle_count  out  CNT_W  enabled cycles since last CLEAR/reset

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, pipe_en=0, if_flush=0, pipe_clear=0, halted=0, done=0, cycle_count=0, drain counter=0. Reset mid-operation aborts any state; the next cycle is IDLE.
- All outputs are registered and reflect the current state. A command is accepted on the cycle of the handshake; the state changes on the following edge.
- halt_seen = (instruction_IF[31:26]==HALT_OPCODE) && !stallF && pipe_en.
- States:
  - IDLE: pipe_en=0, cmd_ready=1.
    - RUN -> RUN.
    - STEP -> STEP.
    - CLEAR -> CLEAR.
    - PAUSE is accepted and ignored.
  - RUN: pipe_en=1, cmd_ready=1.
    - halt_seen -> DRAIN, with drain counter loaded with DRAIN_CYCLES.
    - Otherwise an accepted PAUSE -> IDLE.
    - RUN, STEP and CLEAR are accepted and dropped.
    - halt_seen has priority over a same-cycle PAUSE; the PAUSE is consumed.
  - STEP: exactly one cycle with pipe_en=1, cmd_ready=0.
    - halt_seen -> DRAIN.
    - Otherwise -> IDLE.
  - DRAIN: pipe_en=1, if_flush=1, cmd_ready=0. The drain counter decrements each cycle.
    - At 1 -> HALTED, with done=1 for one cycle.
    - A stallF during DRAIN does not pause the countdown.
  - HALTED: pipe_en=0, halted=1, cmd_ready=1.
    - CLEAR -> CLEAR.
    - RUN, STEP and PAUSE are accepted and ignored.
  - CLEAR: pipe_clear=1 for one cycle, pipe_en=0, cmd_ready=0. cycle_count is zeroed at the same edge. -> IDLE.
- cycle_count increments on every edge where pipe_en=1 (RUN, STEP, DRAIN), and saturates at all-ones without wrapping.
- DRAIN_CYCLES=0 is illegal. The bench checks this with an assertion.

Decomposition:
- Shared header pipeline_ctrl_defs.vh holds:
  - command codes CMD_PAUSE/RUN/STEP/CLEAR;
  - state encodings S_IDLE, S_RUN, S_STEP, S_DRAIN, S_HALTED, S_CLEAR;
  - the HALT opcode constant, which is shared with the control unit.
- One sub-module, sat_counter (parameterised width, enable, sync clear, saturate), implements cycle_count.
- The FSM and drain counter stay in the top module.

Test Plan:
1. Reset: hold reset=0 for 3 cycles, then release -> IDLE, pipe_en=0, cmd_ready=1, cycle_count=0, halted=0.
2. Step: three STEP commands separated by idle cycles; no HALT fetched -> exactly 3 single-cycle pipe_en pulses, cycle_count=3, state back in IDLE after each.
3. Run to halt: RUN with the HALT opcode in IF at cycle 10 after the run starts, stallF=0 ->
   - DRAIN for 4 cycles with if_flush=1;
   - done pulse, then halted=1 and pipe_en=0;
   - cycle_count=14 (10 RUN + 4 DRAIN).
4. HALT under stall: HALT in IF with stallF=1 for 2 cycles, then stallF=0 -> DRAIN entered only after the stall drops; the 2 stalled cycles still count.
5. Simultaneous: PAUSE asserted in the same cycle halt_seen=1 -> DRAIN is taken, the PAUSE is consumed, and HALTED is reached after 4 cycles.
6. Clear and reset mid-run:
   - In HALTED, CLEAR -> one-cycle pipe_clear, cycle_count=0, then IDLE.
   - During DRAIN, reset=0 for 1 cycle -> IDLE, with done never pulsed.

Source files
------------

// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared command codes, controller states and HALT opcode for the pipeline run controller.
// The HALT opcode constant is also consumed by the instruction decoder's control unit.
package pipeline_run_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_PAUSE = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4,
    S_CLEAR  = 3'd5
  } state_e;

  localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;

  function automatic logic state_pipe_en(input state_e s);
    return (s == S_RUN) || (s == S_STEP) || (s == S_DRAIN);
  endfunction

  function automatic logic state_busy(input state_e s);
    return (s == S_RUN) || (s == S_STEP) || (s == S_DRAIN) || (s == S_CLEAR);
  endfunction

  function automatic logic state_cmd_ready(input state_e s);
    return (s == S_IDLE) || (s == S_RUN) || (s == S_HALTED);
  endfunction

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; count updates one edge after en/clr.
// Holds at all-ones instead of wrapping; clear wins over enable.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Debug-host run/step/clear controller gating the pipeline enable; outputs registered, state moves one edge after a command handshake.
// Commands are only accepted (cmd_ready) in IDLE, RUN and HALTED; HALT fetch drains the pipe then freezes it.
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int         CNT_W        = 32,
  parameter logic [5:0] HALT_OPCODE  = HALT_OPCODE_DEF,
  parameter int         DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic [31:0]      instruction_IF,
  input  logic             stallF,
  output logic             pipe_en,
  output logic             if_flush,
  output logic             pipe_clear,
  output logic             halted,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  state_e               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 pipe_en_q, pipe_en_d;
  logic                 if_flush_q, if_flush_d;
  logic                 pipe_clear_q, pipe_clear_d;
  logic                 halted_q, halted_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 cmd_ready_q, cmd_ready_d;

  cmd_e                 cmd_in;
  logic                 cmd_fire;
  logic                 halt_seen;
  logic                 unused_instr_bits;

  assign cmd_in            = cmd_e'(cmd);
  assign cmd_fire          = cmd_valid && cmd_ready_q;
  assign halt_seen         = (instruction_IF[31:26] == HALT_OPCODE) && !stallF && pipe_en_q;
  assign unused_instr_bits = ^instruction_IF[25:0];

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_in)
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_CLEAR: state_d = S_CLEAR;
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        // A HALT fetch outranks a same-cycle PAUSE, which is simply consumed.
        if (halt_seen) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cmd_fire && (cmd_in == CMD_PAUSE)) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (halt_seen) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DRAIN_W'(1);
        if (drain_q <= DRAIN_W'(1)) begin
          state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (cmd_fire && (cmd_in == CMD_CLEAR)) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pipe_en_d    = state_pipe_en(state_d);
    if_flush_d   = (state_d == S_DRAIN);
    pipe_clear_d = (state_d == S_CLEAR);
    halted_d     = (state_d == S_HALTED);
    done_d       = (state_d == S_HALTED) && (state_q == S_DRAIN);
    busy_d       = state_busy(state_d);
    cmd_ready_d  = state_cmd_ready(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      drain_q      <= '0;
      pipe_en_q    <= 1'b0;
      if_flush_q   <= 1'b0;
      pipe_clear_q <= 1'b0;
      halted_q     <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      pipe_en_q    <= pipe_en_d;
      if_flush_q   <= if_flush_d;
      pipe_clear_q <= pipe_clear_d;
      halted_q     <= halted_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  // Counter zeroes on the same edge that enters CLEAR and counts every enabled edge.
  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pipe_en_q),
    .clr   (pipe_clear_d),
    .count (cycle_count)
  );

  assign pipe_en    = pipe_en_q;
  assign if_flush   = if_flush_q;
  assign pipe_clear = pipe_clear_q;
  assign halted     = halted_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign cmd_ready  = cmd_ready_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed-sequence bench with randomized run lengths, instructions and dropped commands.
// Expectations come from per-state output tables and scenario-level cycle arithmetic.
module tb_pipeline_run_ctrl;

  localparam int         CNT_W        = 6;
  localparam int         DRAIN_CYCLES = 4;
  localparam logic [5:0] HALT_OP      = 6'b111111;
  localparam int         CNT_MAX      = (1 << CNT_W) - 1;

  // Expected {pipe_en, if_flush, pipe_clear, halted, done, busy, cmd_ready} per state.
  localparam logic [6:0] O_IDLE   = 7'b0000001;
  localparam logic [6:0] O_RUN    = 7'b1000011;
  localparam logic [6:0] O_STEP   = 7'b1000010;
  localparam logic [6:0] O_DRAIN  = 7'b1100010;
  localparam logic [6:0] O_DONE   = 7'b0001101;
  localparam logic [6:0] O_HALTED = 7'b0001001;
  localparam logic [6:0] O_CLEAR  = 7'b0010010;

  localparam logic [1:0] C_PAUSE = 2'b00;
  localparam logic [1:0] C_RUN   = 2'b01;
  localparam logic [1:0] C_STEP  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd = 2'b00;
  logic             cmd_ready;
  logic [31:0]      instruction_IF = 32'h0;
  logic             stallF = 1'b0;
  logic             pipe_en, if_flush, pipe_clear, halted, done, busy;
  logic [CNT_W-1:0] cycle_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  pipeline_run_ctrl #(
    .CNT_W        (CNT_W),
    .HALT_OPCODE  (HALT_OP),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd            (cmd),
    .cmd_ready      (cmd_ready),
    .instruction_IF (instruction_IF),
    .stallF         (stallF),
    .pipe_en        (pipe_en),
    .if_flush       (if_flush),
    .pipe_clear     (pipe_clear),
    .halted         (halted),
    .done           (done),
    .busy           (busy),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    assert (DRAIN_CYCLES > 0)
      else $fatal(1, "FAIL drain_param observed=%0d required>0", DRAIN_CYCLES);
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic logic [31:0] nonhalt_instr();
    logic [5:0]  op;
    logic [31:0] r;
    op = 6'($urandom_range(0, 62));
    r  = $urandom;
    return {op, r[25:0]};
  endfunction

  function automatic logic [31:0] halt_instr();
    logic [31:0] r;
    r = $urandom;
    return {HALT_OP, r[25:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_o(input string tag, input logic [6:0] exp);
    chk(tag, {25'b0, pipe_en, if_flush, pipe_clear, halted, done, busy, cmd_ready}, {25'b0, exp});
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, {{(32-CNT_W){1'b0}}, cycle_count}, 32'(sat(exp_cnt)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick();
    cmd_valid = 1'b0;
    cmd       = 2'($urandom_range(0, 3));
  endtask

  // Free-running RUN cycles with no HALT; random stalls and dropped RUN/STEP/CLEAR commands.
  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      instruction_IF = nonhalt_instr();
      stallF         = 1'($urandom_range(0, 1));
      cmd_valid      = ($urandom_range(0, 2) == 0);
      cmd            = 2'($urandom_range(1, 3));
      chk_o({tag, "_run_o"}, O_RUN);
      chk_cnt({tag, "_run_cnt"});
      tick();
      exp_cnt++;
    end
    cmd_valid = 1'b0;
    stallF    = 1'b0;
  endtask

  // Called on the first DRAIN cycle; walks drain, done pulse and first HALTED cycle.
  task automatic drain_to_halt(input string tag);
    for (int d = 0; d < DRAIN_CYCLES; d++) begin
      instruction_IF = $urandom;
      stallF         = 1'($urandom_range(0, 1));
      cmd_valid      = 1'($urandom_range(0, 1));
      cmd            = 2'($urandom_range(0, 3));
      chk_o({tag, "_drain_o"}, O_DRAIN);
      chk_cnt({tag, "_drain_cnt"});
      tick();
      exp_cnt++;
    end
    cmd_valid = 1'b0;
    stallF    = 1'b0;
    chk_o({tag, "_done_o"}, O_DONE);
    chk_cnt({tag, "_done_cnt"});
    tick();
    chk_o({tag, "_halted_o"}, O_HALTED);
  endtask

  task automatic clear_from_here(input string tag);
    send(C_CLEAR);
    exp_cnt = 0;
    chk_o({tag, "_clear_o"}, O_CLEAR);
    chk_cnt({tag, "_clear_cnt"});
    tick();
    chk_o({tag, "_clear_idle_o"}, O_IDLE);
  endtask

  initial begin
    int m;

    // Reset held for three edges with garbage on the command port.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid      = 1'($urandom_range(0, 1));
      cmd            = 2'($urandom_range(0, 3));
      instruction_IF = $urandom;
      tick();
    end
    reset     = 1'b1;
    cmd_valid = 1'b0;
    chk_o("reset_o", O_IDLE);
    chk("reset_cnt", {{(32-CNT_W){1'b0}}, cycle_count}, 32'd0);
    tick();
    chk_o("reset_idle_hold_o", O_IDLE);

    // Three single steps separated by idle gaps; commands during STEP must be refused.
    exp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      m = $urandom_range(1, 3);
      for (int g = 0; g < m; g++) begin
        instruction_IF = $urandom;
        tick();
        chk_o("step_gap_o", O_IDLE);
      end
      instruction_IF = nonhalt_instr();
      send(C_STEP);
      chk_o("step_o", O_STEP);
      chk_cnt("step_cnt_during");
      cmd_valid = 1'b1;
      cmd       = C_RUN;
      tick();
      cmd_valid = 1'b0;
      exp_cnt++;
      chk_o("step_back_idle_o", O_IDLE);
      chk_cnt("step_cnt_after");
    end
    chk("step_total_cnt", {{(32-CNT_W){1'b0}}, cycle_count}, 32'd3);

    // PAUSE in IDLE is a no-op; CLEAR from IDLE zeroes the count.
    send(C_PAUSE);
    chk_o("idle_pause_o", O_IDLE);
    clear_from_here("idle");

    // Run to HALT fetched on the 10th RUN cycle.
    instruction_IF = nonhalt_instr();
    send(C_RUN);
    run_cycles(9, "halt10");
    instruction_IF = halt_instr();
    stallF         = 1'b0;
    chk_o("halt10_fetch_o", O_RUN);
    tick();
    exp_cnt++;
    drain_to_halt("halt10");
    chk("halt10_total_cnt", {{(32-CNT_W){1'b0}}, cycle_count}, 32'd14);

    // HALTED ignores RUN, STEP and PAUSE.
    send(C_RUN);
    chk_o("halted_ign_run_o", O_HALTED);
    send(C_STEP);
    chk_o("halted_ign_step_o", O_HALTED);
    send(C_PAUSE);
    chk_o("halted_ign_pause_o", O_HALTED);
    chk_cnt("halted_cnt_frozen");
    clear_from_here("halted");

    // HALT sits in IF under a 2-cycle stall before being taken.
    instruction_IF = nonhalt_instr();
    send(C_RUN);
    run_cycles($urandom_range(1, 5), "stall");
    for (int s = 0; s < 2; s++) begin
      instruction_IF = halt_instr();
      stallF         = 1'b1;
      chk_o("stall_hold_o", O_RUN);
      chk_cnt("stall_hold_cnt");
      tick();
      exp_cnt++;
    end
    stallF = 1'b0;
    chk_o("stall_release_o", O_RUN);
    tick();
    exp_cnt++;
    drain_to_halt("stall");
    chk_cnt("stall_total_cnt");
    clear_from_here("stall");

    // PAUSE in the same cycle as the HALT fetch is consumed by the drain.
    instruction_IF = nonhalt_instr();
    send(C_RUN);
    run_cycles($urandom_range(1, 6), "simul");
    instruction_IF = halt_instr();
    stallF         = 1'b0;
    cmd_valid      = 1'b1;
    cmd            = C_PAUSE;
    chk_o("simul_fetch_o", O_RUN);
    tick();
    cmd_valid = 1'b0;
    exp_cnt++;
    drain_to_halt("simul");
    tick();
    chk_o("simul_stays_halted_o", O_HALTED);
    chk_cnt("simul_total_cnt");
    clear_from_here("simul");

    // Plain PAUSE out of RUN; the PAUSE cycle itself is still enabled.
    instruction_IF = nonhalt_instr();
    send(C_RUN);
    run_cycles($urandom_range(2, 8), "pause");
    instruction_IF = nonhalt_instr();
    chk_o("pause_cycle_o", O_RUN);
    send(C_PAUSE);
    exp_cnt++;
    chk_o("pause_idle_o", O_IDLE);
    chk_cnt("pause_cnt");

    // STEP that fetches HALT goes straight into the drain.
    instruction_IF = halt_instr();
    send(C_STEP);
    chk_o("step_halt_o", O_STEP);
    tick();
    exp_cnt++;
    drain_to_halt("step_halt");
    chk_cnt("step_halt_cnt");
    clear_from_here("step_halt");

    // Reset mid-drain aborts to IDLE without any done pulse.
    instruction_IF = nonhalt_instr();
    send(C_RUN);
    run_cycles(2, "rst");
    instruction_IF = halt_instr();
    tick();
    chk_o("rst_drain1_o", O_DRAIN);
    tick();
    chk_o("rst_drain2_o", O_DRAIN);
    reset = 1'b0;
    tick();
    reset   = 1'b1;
    exp_cnt = 0;
    chk_o("rst_abort_o", O_IDLE);
    chk_cnt("rst_abort_cnt");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_o("rst_no_done_o", O_IDLE);
    end

    // Long run saturates the narrow counter at all-ones.
    instruction_IF = nonhalt_instr();
    send(C_RUN);
    run_cycles(CNT_MAX + 8, "sat");
    instruction_IF = nonhalt_instr();
    send(C_PAUSE);
    exp_cnt++;
    chk_o("sat_idle_o", O_IDLE);
    chk("sat_cnt", {{(32-CNT_W){1'b0}}, cycle_count}, 32'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
